// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between uart_rx/uart_tx and the firing/ADC logic.
// Decodes one-byte commands, pulses fire or requests the ADC, and answers over uart_tx.
module uart_cmd_ctrl #(
   parameter int unsigned N_CODES     = 6,
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter logic [7:0]  NAK_BYTE    = 8'h5A,
   parameter int unsigned TIMEOUT_CYC = 48000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_done,
   input  logic [7:0]  data_received,
   input  logic        parity_error,
   input  logic        tx_busy,
   output logic        start_tx,
   output logic [7:0]  data_to_tx,
   output logic [2:0]  fire_code,
   output logic        code_valid,
   output logic        fire,
   output logic        adc_req,
   input  logic        adc_done,
   input  logic [11:0] adc_data,
   output logic        busy,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_FIRE, S_ADC_WAIT, S_LOAD, S_SEND, S_TXW_HI, S_TXW_LO
   } state_t;

   localparam logic [1:0] OP_SET  = 2'b00;
   localparam logic [1:0] OP_FIRE = 2'b01;
   localparam logic [1:0] OP_ADC  = 2'b10;
   localparam int         TW      = $clog2(TIMEOUT_CYC + 1);

   state_t         r_state;
   state_t         w_next;
   logic [1:0]     r_opcode;
   logic [2:0]     r_code;
   logic           r_perr;
   logic [2:0]     r_fire_code;
   logic           r_code_valid;
   logic [7:0]     r_q0;
   logic [7:0]     r_q1;
   logic [1:0]     r_q_cnt;
   logic [7:0]     r_data_to_tx;
   logic [7:0]     r_err_count;
   logic [TW-1:0]  r_timer;

   logic           w_code_ok;
   logic           w_dec_set;
   logic           w_dec_fire;
   logic           w_dec_adc;
   logic           w_dec_nak;
   logic           w_timeout;
   logic           w_drop;
   logic           w_nak;
   logic           w_tx_to;
   logic           w_waiting;
   logic [8:0]     w_err_sum;

   assign w_code_ok  = ({29'd0, r_code} < N_CODES);
   assign w_dec_set  = !r_perr && (r_opcode == OP_SET) && w_code_ok;
   assign w_dec_fire = !r_perr && (r_opcode == OP_FIRE) && r_code_valid;
   assign w_dec_adc  = !r_perr && (r_opcode == OP_ADC);
   assign w_dec_nak  = !w_dec_set && !w_dec_fire && !w_dec_adc;
   assign w_timeout  = (r_timer == TW'(TIMEOUT_CYC - 1));

   // Error sources can coincide (a dropped byte during a NAK), so they are summed.
   assign w_drop    = rx_done && (r_state != S_IDLE);
   assign w_nak     = ((r_state == S_DECODE) && w_dec_nak) ||
                      ((r_state == S_ADC_WAIT) && !adc_done && w_timeout);
   assign w_tx_to   = (r_state == S_TXW_HI) && !tx_busy && w_timeout;
   assign w_err_sum = {1'b0, r_err_count} + 9'(w_drop) + 9'(w_nak) + 9'(w_tx_to);
   assign w_waiting = ((r_state == S_ADC_WAIT) || (r_state == S_TXW_HI)) && (w_next == r_state);

   assign data_to_tx = r_data_to_tx;
   assign fire_code  = r_fire_code;
   assign code_valid = r_code_valid;
   assign err_count  = r_err_count;

   // NOTE: reset is synchronous; every register clears inside the clocked block.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets a default before the case so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (rx_done) w_next = S_DECODE;
         S_DECODE:   if (w_dec_fire)     w_next = S_FIRE;
                     else if (w_dec_adc) w_next = S_ADC_WAIT;
                     else                w_next = S_LOAD;
         S_FIRE:     w_next = S_LOAD;
         S_ADC_WAIT: if (adc_done || w_timeout) w_next = S_LOAD;
         S_LOAD:     if (!tx_busy) w_next = S_SEND;
         S_SEND:     w_next = S_TXW_HI;
         S_TXW_HI:   if (tx_busy || w_timeout) w_next = S_TXW_LO;
         S_TXW_LO:   if (!tx_busy) w_next = (r_q_cnt != 2'd0) ? S_LOAD : S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      start_tx = 1'b0;
      fire     = 1'b0;
      adc_req  = 1'b0;
      busy     = 1'b1;
      case (r_state)
         S_IDLE:     busy     = 1'b0;
         S_FIRE:     fire     = 1'b1;
         S_ADC_WAIT: adc_req  = 1'b1;
         S_SEND:     start_tx = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_opcode     <= 2'd0;
         r_code       <= 3'd0;
         r_perr       <= 1'b0;
         r_fire_code  <= 3'd0;
         r_code_valid <= 1'b0;
         r_q0         <= 8'd0;
         r_q1         <= 8'd0;
         r_q_cnt      <= 2'd0;
         r_data_to_tx <= 8'd0;
         r_err_count  <= 8'd0;
         r_timer      <= '0;
      end else begin
         if ((r_state == S_IDLE) && rx_done) begin
            r_opcode <= data_received[7:6];
            r_code   <= data_received[2:0];
            r_perr   <= parity_error;
         end
         case (r_state)
            S_DECODE: begin
               if (w_dec_set) begin
                  r_fire_code  <= r_code;
                  r_code_valid <= 1'b1;
               end
               if (w_dec_set || w_dec_nak) begin
                  r_q0    <= w_dec_set ? ACK_BYTE : NAK_BYTE;
                  r_q_cnt <= 2'd1;
               end
            end
            S_FIRE: begin
               r_q0    <= ACK_BYTE;
               r_q_cnt <= 2'd1;
            end
            S_ADC_WAIT: begin
               if (adc_done) begin
                  r_q0    <= {4'h0, adc_data[11:8]};
                  r_q1    <= adc_data[7:0];
                  r_q_cnt <= 2'd2;
               end else if (w_timeout) begin
                  r_q0    <= NAK_BYTE;
                  r_q_cnt <= 2'd1;
               end
            end
            S_LOAD: begin
               if (!tx_busy) begin
                  r_data_to_tx <= r_q0;
                  r_q0         <= r_q1;
                  r_q_cnt      <= r_q_cnt - 2'd1;
               end
            end
            default: ;
         endcase
         r_timer     <= w_waiting ? r_timer + TW'(1) : '0;
         r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a table of single-byte commands plus
// hand-written sequences for fire latency, ADC read/timeout, drops, reset and saturation.
module tb_uart_cmd_ctrl;

   localparam int TO     = 300;
   localparam int TX_LEN = 6;
   localparam int LIMIT  = 2000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_done = 1'b0;
   logic [7:0]  data_received = 8'd0;
   logic        parity_error = 1'b0;
   logic        tx_busy = 1'b0;
   logic        adc_done = 1'b0;
   logic [11:0] adc_data = 12'd0;
   logic        start_tx, code_valid, fire, adc_req, busy;
   logic [7:0]  data_to_tx, err_count;
   logic [2:0]  fire_code;

   uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .rx_done(rx_done), .data_received(data_received),
      .parity_error(parity_error), .tx_busy(tx_busy), .start_tx(start_tx),
      .data_to_tx(data_to_tx), .fire_code(fire_code), .code_valid(code_valid),
      .fire(fire), .adc_req(adc_req), .adc_done(adc_done), .adc_data(adc_data),
      .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         rx_cyc = 0;
   int         fire_cnt = 0;
   int         fire_cyc = -1;
   int         busy_cnt = 0;
   int         viol = 0;
   int         exp_err = 0;
   logic [7:0] tx_q[$];

   always @(posedge clk) cyc++;

   // uart_tx stand-in: busy rises with start_tx and stays up TX_LEN cycles.
   always @(negedge clk) begin
      if (fire) begin
         fire_cnt++;
         fire_cyc = cyc;
      end
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (start_tx) begin
         if (tx_busy) viol++;
         tx_q.push_back(data_to_tx);
         tx_busy  = 1'b1;
         busy_cnt = TX_LEN;
      end
   end

   typedef struct {
      logic [7:0] cmd;
      logic       pe;
      logic [7:0] exp_tx;
      logic [2:0] exp_code;
      logic       exp_valid;
      logic [7:0] exp_err;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] txb(input int i);
      return (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic pe);
      step();
      rx_done       = 1'b1;
      data_received = b;
      parity_error  = pe;
      rx_cyc        = cyc;
      step();
      rx_done      = 1'b0;
      parity_error = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || tx_busy) && n < LIMIT) begin
         step();
         n++;
      end
      if (n >= LIMIT) begin
         checks++;
         failures++;
         $display("FAIL %s: idle not reached within %0d cycles", name, LIMIT);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      int f0;

      vecs[0] = '{8'h40, 1'b0, 8'h5A, 3'd0, 1'b0, 8'd1};
      vecs[1] = '{8'h03, 1'b0, 8'hA5, 3'd3, 1'b1, 8'd1};
      vecs[2] = '{8'h06, 1'b0, 8'h5A, 3'd3, 1'b1, 8'd2};
      vecs[3] = '{8'h07, 1'b0, 8'h5A, 3'd3, 1'b1, 8'd3};
      vecs[4] = '{8'h05, 1'b0, 8'hA5, 3'd5, 1'b1, 8'd3};
      vecs[5] = '{8'h02, 1'b1, 8'h5A, 3'd5, 1'b1, 8'd4};
      vecs[6] = '{8'hC0, 1'b0, 8'h5A, 3'd5, 1'b1, 8'd5};
      vecs[7] = '{8'h3A, 1'b0, 8'hA5, 3'd2, 1'b1, 8'd5};
      vecs[8] = '{8'h05, 1'b0, 8'hA5, 3'd5, 1'b1, 8'd5};

      // Power-up reset
      repeat (4) @(posedge clk);
      step();
      check("reset outputs",
            {24'd0, start_tx, fire, adc_req, busy, code_valid, fire_code},
            32'd0);
      check("reset data/err", {16'd0, data_to_tx, err_count}, 32'd0);
      reset = 1'b1;
      step();
      check("after release busy", {31'd0, busy}, 32'd0);

      // Single-byte command table
      for (int i = 0; i < 9; i++) begin
         tx_q.delete();
         send(vecs[i].cmd, vecs[i].pe);
         wait_idle($sformatf("vec%0d idle", i));
         check($sformatf("vec%0d tx count", i), tx_q.size(), 1);
         check($sformatf("vec%0d tx byte", i), txb(0), 32'(vecs[i].exp_tx));
         check($sformatf("vec%0d fire_code", i), 32'(fire_code), 32'(vecs[i].exp_code));
         check($sformatf("vec%0d code_valid", i), 32'(code_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_err));
      end
      check("no fire during table", fire_cnt, 0);
      exp_err = 5;

      // Valid fire with code 5
      tx_q.delete();
      f0 = fire_cnt;
      send(8'h40, 1'b0);
      wait_idle("fire idle");
      check("fire pulse count", fire_cnt - f0, 1);
      check("fire latency", fire_cyc - rx_cyc, 2);
      check("fire ack", txb(0), 32'hA5);
      check("fire tx count", tx_q.size(), 1);
      check("fire code", 32'(fire_code), 32'd5);

      // ADC read: done after 100 cycles of adc_req
      tx_q.delete();
      send(8'h80, 1'b0);
      n = 0;
      k = 0;
      while (k < LIMIT && n < 100) begin
         step();
         k++;
         if (adc_req) n++;
      end
      check("adc_req cycles before done", n, 100);
      adc_done = 1'b1;
      adc_data = 12'hABC;
      step();
      adc_done = 1'b0;
      adc_data = 12'd0;
      check("adc_req drops after done", 32'(adc_req), 32'd0);
      wait_idle("adc idle");
      check("adc tx count", tx_q.size(), 2);
      check("adc byte hi", txb(0), 32'h0A);
      check("adc byte lo", txb(1), 32'hBC);
      check("adc err unchanged", 32'(err_count), 32'(exp_err));

      // ADC timeout
      tx_q.delete();
      send(8'h80, 1'b0);
      n = 0;
      k = 0;
      while (k < LIMIT) begin
         step();
         k++;
         if (adc_req) n++;
         else if (n > 0) break;
      end
      check("adc_req cycles to timeout", n, TO);
      wait_idle("timeout idle");
      exp_err++;
      check("timeout tx count", tx_q.size(), 1);
      check("timeout nak", txb(0), 32'h5A);
      check("timeout err_count", 32'(err_count), 32'(exp_err));

      // adc_done while idle is ignored
      tx_q.delete();
      step();
      adc_done = 1'b1;
      step();
      adc_done = 1'b0;
      repeat (5) step();
      check("stray adc_done busy", 32'(busy), 32'd0);
      check("stray adc_done tx", tx_q.size(), 0);

      // rx_done during TXW_LO is dropped
      tx_q.delete();
      f0 = fire_cnt;
      send(8'h03, 1'b0);
      k = 0;
      while (!tx_busy && k < LIMIT) begin
         step();
         k++;
      end
      check("txw_lo reached", 32'(tx_busy), 32'd1);
      step();
      send(8'h40, 1'b0);
      wait_idle("drop idle");
      exp_err++;
      check("drop tx count", tx_q.size(), 1);
      check("drop tx byte", txb(0), 32'hA5);
      check("drop err_count", 32'(err_count), 32'(exp_err));
      check("drop no fire", fire_cnt - f0, 0);
      check("drop fire_code", 32'(fire_code), 32'd3);

      // Reset during ADC_WAIT
      tx_q.delete();
      send(8'h80, 1'b0);
      repeat (5) step();
      check("adc_req before reset", 32'(adc_req), 32'd1);
      reset = 1'b0;
      step();
      check("reset aborts adc_req", 32'(adc_req), 32'd0);
      check("reset aborts state",
            {27'd0, busy, code_valid, fire_code}, 32'd0);
      check("reset clears err", 32'(err_count), 32'd0);
      step();
      reset = 1'b1;
      repeat (40) step();
      check("no tx after reset", tx_q.size(), 0);

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         send(8'hC0, 1'b0);
         wait_idle("sat idle");
      end
      check("err_count saturates", 32'(err_count), 32'hFF);

      check("start_tx while tx_busy", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
